// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life neighbourhood streamer
// and the downstream cell evaluator.
package life_pkg;

    // Window controller states: fill the frame buffer, then stream it out.
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } life_state_e;

    // Bit positions of each neighbour inside the 8-bit neighbourhood word.
    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    // Number of live neighbours in a neighbourhood word (for the evaluator).
    function automatic logic [3:0] nb_count(input logic [7:0] nb);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt = cnt + {3'd0, nb[k]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/life_frame_buf.sv
// W*H-bit frame buffer with one write port and a combinational 3x3
// neighbourhood fetch around (i_x, i_y); WRAP selects dead border or torus.
module life_frame_buf
    import life_pkg::*;
#(
    parameter int W    = 8,
    parameter int H    = 8,
    parameter int WRAP = 0,
    parameter int IW   = $clog2(W * H),
    parameter int XW   = $clog2(W),
    parameter int YW   = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic          i_wdata,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic          o_self,
    output logic [7:0]    o_nb
);

    logic [W*H-1:0] r_frame;
    int             w_cx;
    int             w_cy;

    // Read one cell at (cx+dx, cy+dy); off-grid cells are dead unless the grid wraps.
    function automatic logic fetch(input logic [W*H-1:0] frame,
                                   input int cx, input int cy,
                                   input int dx, input int dy);
        int             nx;
        int             ny;
        logic [W*H-1:0] sh;
        logic           v;
        nx = cx + dx;
        ny = cy + dy;
        sh = '0;
        v  = 1'b0;
        if (WRAP != 0) begin
            nx = (nx + W) % W;
            ny = (ny + H) % H;
            sh = frame >> (ny * W + nx);
            v  = sh[0];
        end else if ((nx >= 0) && (nx < W) && (ny >= 0) && (ny < H)) begin
            sh = frame >> (ny * W + nx);
            v  = sh[0];
        end else begin
            v  = 1'b0;
        end
        return v;
    endfunction

    // Frame storage: cleared on reset, one cell written per accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
        end else if (i_we) begin
            r_frame[i_widx] <= i_wdata;
        end else begin
            r_frame <= r_frame;
        end
    end

    // Neighbourhood fetch around the current coordinates, no registers in the path.
    always_comb begin
        w_cx         = int'(i_x);
        w_cy         = int'(i_y);
        o_self       = fetch(r_frame, w_cx, w_cy,  32'sd0,  32'sd0);
        o_nb         = 8'h00;
        o_nb[NB_NW]  = fetch(r_frame, w_cx, w_cy, -32'sd1, -32'sd1);
        o_nb[NB_N]   = fetch(r_frame, w_cx, w_cy,  32'sd0, -32'sd1);
        o_nb[NB_NE]  = fetch(r_frame, w_cx, w_cy,  32'sd1, -32'sd1);
        o_nb[NB_W]   = fetch(r_frame, w_cx, w_cy, -32'sd1,  32'sd0);
        o_nb[NB_E]   = fetch(r_frame, w_cx, w_cy,  32'sd1,  32'sd0);
        o_nb[NB_SW]  = fetch(r_frame, w_cx, w_cy, -32'sd1,  32'sd1);
        o_nb[NB_S]   = fetch(r_frame, w_cx, w_cy,  32'sd0,  32'sd1);
        o_nb[NB_SE]  = fetch(r_frame, w_cx, w_cy,  32'sd1,  32'sd1);
    end

endmodule

// File: rtl/life_window.sv
// Loads a W x H frame of cells in raster order, then streams every cell
// with its 8-neighbourhood to a downstream evaluator under valid/ready.
module life_window
    import life_pkg::*;
#(
    parameter int W    = 8,
    parameter int H    = 8,
    parameter int WRAP = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_cell,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_self,
    output logic [7:0]           out_neighbors,
    output logic [$clog2(W)-1:0] out_x,
    output logic [$clog2(H)-1:0] out_y,
    output logic                 out_last
);

    localparam int N  = W * H;
    localparam int IW = $clog2(N);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(H - 1);

    life_state_e   r_state;
    life_state_e   w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_out_last;
    logic          w_in_ready_nxt;
    logic          w_out_valid_nxt;
    logic          w_out_last_nxt;
    logic          w_accept;
    logic          w_load_done;
    logic          w_xfer;

    // in_ready is only ever high in LOAD, so it alone gates buffer writes.
    assign w_accept    = in_valid & r_in_ready;
    assign w_load_done = w_accept & (r_idx == IDX_LAST);
    assign w_xfer      = r_out_valid & out_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: full frame loaded -> EMIT, last cell taken -> LOAD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_load_done) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_EMIT: begin
                if (w_xfer && r_out_last) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Next output coordinates: advance in raster order on each transfer.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_xfer) begin
            if (r_x == X_LAST) begin
                w_x_nxt = '0;
                if (r_y == Y_LAST) begin
                    w_y_nxt = '0;
                end else begin
                    w_y_nxt = r_y + YW'(32'd1);
                end
            end else begin
                w_x_nxt = r_x + XW'(32'd1);
                w_y_nxt = r_y;
            end
        end else begin
            w_x_nxt = r_x;
            w_y_nxt = r_y;
        end
    end

    // Output decode: the first EMIT cycle is a gap while the last write settles.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        case (w_state_nxt)
            ST_LOAD: begin
                w_in_ready_nxt  = 1'b1;
                w_out_valid_nxt = 1'b0;
            end
            ST_EMIT: begin
                w_in_ready_nxt  = 1'b0;
                w_out_valid_nxt = (r_state == ST_EMIT);
            end
            default: begin
                w_in_ready_nxt  = 1'b0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
        w_out_last_nxt = w_out_valid_nxt & (w_x_nxt == X_LAST) & (w_y_nxt == Y_LAST);
    end

    // Registered handshake and last-cell flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    // Load index: counts accepted cells, back to 0 once the frame is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            if (w_load_done) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IW'(32'd1);
            end
        end else begin
            r_idx <= r_idx;
        end
    end

    // Output coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end
    end

    life_frame_buf #(
        .W    (W),
        .H    (H),
        .WRAP (WRAP)
    ) u_frame_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_accept),
        .i_widx  (r_idx),
        .i_wdata (in_cell),
        .i_x     (r_x),
        .i_y     (r_y),
        .o_self  (out_self),
        .o_nb    (out_neighbors)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_x     = r_x;
    assign out_y     = r_y;

endmodule

// File: doc/life_window.md
LIFE_WINDOW -- requirements
Module: life_window

Interface
REQ-001 SHALL have parameter W, default 8, meaning grid width in cells (legal range 3..64).
REQ-002 SHALL have parameter H, default 8, meaning grid height in cells (legal range 3..64).
REQ-003 SHALL have parameter WRAP, default 0, meaning 0 = dead border and 1 = toroidal grid.
REQ-004 SHALL have port clk, input, 1, the single clock; every register samples on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, the upstream cell is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a cell.
REQ-008 SHALL have port in_cell, input, 1, cell state (1 = alive), delivered in raster order: x fastest, starting at (0,0).
REQ-009 SHALL have port out_valid, output, 1, a neighbourhood is presented.
REQ-010 SHALL have port out_ready, input, 1, the downstream cell evaluator takes it.
REQ-011 SHALL have port out_self, output, 1, state of cell (out_x,out_y).
REQ-012 SHALL have port out_neighbors, output, 8, neighbour states: bit0 NW, bit1 N, bit2 NE, bit3 W, bit4 E, bit5 SW, bit6 S, bit7 SE.
REQ-013 SHALL have port out_x, output, $clog2(W), column of the presented cell.
REQ-014 SHALL have port out_y, output, $clog2(H), row of the presented cell.
REQ-015 SHALL have port out_last, output, 1, high with out_valid for cell (W-1,H-1).

Function
REQ-016 SHALL hold a W*H-bit frame buffer and a two-state FSM, LOAD and EMIT.
REQ-017 SHALL, in LOAD, drive in_ready=1 and out_valid=0; each in_valid&in_ready cycle writes in_cell to the current index, then increments the index.
REQ-018 SHALL enter EMIT on the cycle after the cell at index W*H-1 is accepted; first out_valid rises exactly one cycle after that acceptance.
REQ-019 SHALL, in EMIT, drive in_ready=0 and out_valid=1, and present cells in raster order.
REQ-020 SHALL advance (out_x,out_y) only on out_valid&out_ready; x wraps W-1→0 with y+1.
REQ-021 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on transfer of out_last, return to LOAD on the next cycle with index and (x,y) at 0; the buffer is not cleared.
REQ-023 SHALL, when WRAP=0, read every neighbour outside 0..W-1 × 0..H-1 as 0.
REQ-024 SHALL, when WRAP=1, take neighbour coordinates modulo W and H.
REQ-025 SHALL derive out_self and out_neighbors combinationally from the buffer and the current (x,y); there SHALL be no pipeline bubble between consecutive transfers.
REQ-026 SHALL ignore in_cell whenever in_ready=0.

Reset
REQ-027 SHALL, while rst_n=0, force state=LOAD, index=0, x=y=0, buffer all 0, out_valid=0, out_last=0 and in_ready=0.
REQ-028 SHALL drive in_ready=1 from the first clk edge after rst_n deasserts.
REQ-029 SHALL treat a reset in mid-LOAD or mid-EMIT as a full abort; the partial frame is discarded.

Structure
REQ-030 SHALL take the FSM state enum and the neighbour bit-index constants (NB_NW..NB_SE) from shared package life_pkg, which the cell evaluator also uses.
REQ-031 SHALL place the buffer and the 3×3 neighbour-fetch logic (coordinates and WRAP in, self and neighbours out) in sub-module life_frame_buf; the FSM and counters stay in life_window.

Verification
REQ-032 SHALL cover the blinker case: W=H=5, WRAP=0, cells (1,2),(2,2),(3,2) alive → at (2,1) out_self=0, out_neighbors=8'hE0; at (2,2) out_self=1, out_neighbors=8'h18.
REQ-033 SHALL cover the dead border: W=H=4, WRAP=0, all cells alive → (0,0) 8'hD0, (3,3) 8'h0B, (1,1) 8'hFF.
REQ-034 SHALL cover the torus: W=H=4, WRAP=1, only (0,0) alive → (3,3) 8'h80, (1,1) 8'h01, (0,0) out_self=1 with 8'h00.
REQ-035 SHALL cover backpressure: out_ready=0 for 3 cycles at (2,0) → outputs unchanged and in_ready=0; the transfer completes on the cycle out_ready returns to 1.
REQ-036 SHALL cover throughput: in_valid and out_ready held at 1 → W*H input cycles, 1 gap cycle, W*H output cycles with out_last only on the final one, then in_ready=1.
REQ-037 SHALL cover reset abort: rst_n pulsed low at load index 5, then during EMIT at (1,1) → out_valid=0 immediately, and the next frame loads from index 0 with correct outputs.
